// File: rtl/turing_engine.sv
// -----------------------------------------------------------------------------
// turing_engine
//
// Single-tape Turing machine with a loadable transition table and tape.
// While idle, the host loads the table and the tape through their write
// strobes and reads any tape cell back. A start pulse then runs the machine
// until it halts, walks off either end of the tape, or (optionally) uses up
// its step budget. Every machine step takes three cycles: FETCH reads the
// cell under the head, LOOKUP reads the table entry, and EXEC commits the step.
//
// Optional feature:
//   TM_STEP_LIMIT_EN  when defined, a run stops with timeout_o=1 once
//                     step_count reaches MAX_STEPS. When undefined,
//                     timeout_o is constant 0 and runs are unbounded.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   tbl_we_i            table write strobe (ignored while busy)
//   tbl_addr_i          table index {state, symbol}
//   tbl_data_i          entry {write_sym, move[1:0], next_state};
//                       move 00 left, 01 right, 10 stay, 11 halt
//   tape_we_i           tape write strobe (ignored while busy)
//   tape_addr_i         tape cell index for writes and readback
//   tape_wdata_i        symbol to write
//   tape_rdata_o        combinational readback of cell tape_addr_i
//   start_i             one-cycle pulse that starts a run (accepted only in IDLE)
//   start_head_i        initial head position
//   start_state_i       initial machine state
//   busy_o              run in progress (FETCH/LOOKUP/EXEC)
//   done_o              run finished; held until the next start
//   halted_o, fault_o, timeout_o   cause of termination
//   head_o, cur_state_o, step_count_o   live machine status
// -----------------------------------------------------------------------------
module turing_engine #(
  parameter int SW        = 2,
  parameter int SB        = 3,
  parameter int TL        = 32,
  parameter int MAX_STEPS = 1000,
  localparam int HW       = $clog2(TL)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tbl_we_i,
  input  logic [SB+SW-1:0]   tbl_addr_i,
  input  logic [SW+2+SB-1:0] tbl_data_i,
  input  logic               tape_we_i,
  input  logic [HW-1:0]      tape_addr_i,
  input  logic [SW-1:0]      tape_wdata_i,
  output logic [SW-1:0]      tape_rdata_o,
  input  logic               start_i,
  input  logic [HW-1:0]      start_head_i,
  input  logic [SB-1:0]      start_state_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic               timeout_o,
  output logic [HW-1:0]      head_o,
  output logic [SB-1:0]      cur_state_o,
  output logic [15:0]        step_count_o
);

  localparam int EW = SW + 2 + SB;
  localparam int NT = 1 << (SB + SW);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOOKUP = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [HW-1:0] LAST_CELL = HW'(TL - 1);

  localparam logic [1:0] MV_LEFT  = 2'b00;
  localparam logic [1:0] MV_RIGHT = 2'b01;
  localparam logic [1:0] MV_HALT  = 2'b11;

  // Storage deliberately has no reset so programs survive a reset.
  logic [SW-1:0] tape_mem [TL];
  logic [EW-1:0] tbl_mem  [NT];

  logic [2:0]    fsm_q, fsm_d;
  logic [HW-1:0] head_q, head_d;
  logic [SB-1:0] cur_state_q, cur_state_d;
  logic [15:0]   step_q, step_d;
  logic          done_q, done_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic [SW-1:0] sym_q;
  logic [EW-1:0] entry_q;

  logic [SW-1:0] ent_ws;
  logic [1:0]    ent_mv;
  logic [SB-1:0] ent_ns;
  logic [15:0]   step_inc;
  logic          edge_fault;
  logic          exec_wr;

  logic          tape_wr_en;
  logic [HW-1:0] tape_wr_addr;
  logic [SW-1:0] tape_wr_data;

`ifdef TM_STEP_LIMIT_EN
  logic          timeout_q, timeout_d;
`endif

  assign ent_ws = entry_q[EW-1 -: SW];
  assign ent_mv = entry_q[SB+1:SB];
  assign ent_ns = entry_q[SB-1:0];

  assign busy_o       = (fsm_q == FETCH) || (fsm_q == LOOKUP) || (fsm_q == EXEC);
  assign done_o       = done_q;
  assign halted_o     = halted_q;
  assign fault_o      = fault_q;
  assign head_o       = head_q;
  assign cur_state_o  = cur_state_q;
  assign step_count_o = step_q;
  assign tape_rdata_o = tape_mem[tape_addr_i];

`ifdef TM_STEP_LIMIT_EN
  assign timeout_o = timeout_q;
`else
  // Without the limit there is no timeout; MAX_STEPS is never negative,
  // so this folds to a constant 0.
  assign timeout_o = (MAX_STEPS < 0);
`endif

  // The step counter sticks at all-ones rather than wrapping.
  assign step_inc   = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;

  // A move that would leave the tape still commits its write and new state,
  // but the head stays where it is and the run ends.
  assign edge_fault = ((ent_mv == MV_LEFT)  && (head_q == '0)) ||
                      ((ent_mv == MV_RIGHT) && (head_q == LAST_CELL));

  // EXEC writes to the tape on every step except halt.
  assign exec_wr    = (fsm_q == EXEC) && (ent_mv != MV_HALT);

  // A single tape write port, shared by EXEC and the host. The host only
  // gets it while the machine is not running.
  always_comb begin
    tape_wr_en   = 1'b0;
    tape_wr_addr = tape_addr_i;
    tape_wr_data = tape_wdata_i;
    if (exec_wr) begin
      tape_wr_en   = 1'b1;
      tape_wr_addr = head_q;
      tape_wr_data = ent_ws;
    end else if (tape_we_i && !busy_o) begin
      tape_wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (tape_wr_en) begin
      tape_mem[tape_wr_addr] <= tape_wr_data;
    end
    if (tbl_we_i && !busy_o) begin
      tbl_mem[tbl_addr_i] <= tbl_data_i;
    end
  end

  // Next-state logic for the run controller and machine status.
  always_comb begin
    fsm_d       = fsm_q;
    head_d      = head_q;
    cur_state_d = cur_state_q;
    step_d      = step_q;
    done_d      = done_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
`ifdef TM_STEP_LIMIT_EN
    timeout_d   = timeout_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d       = FETCH;
          head_d      = start_head_i;
          cur_state_d = start_state_i;
          step_d      = '0;
          done_d      = 1'b0;
          halted_d    = 1'b0;
          fault_d     = 1'b0;
`ifdef TM_STEP_LIMIT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      FETCH:  fsm_d = LOOKUP;
      LOOKUP: fsm_d = EXEC;
      EXEC: begin
        if (ent_mv == MV_HALT) begin
          halted_d = 1'b1;
          done_d   = 1'b1;
          fsm_d    = FINISH;
        end else begin
          cur_state_d = ent_ns;
          step_d      = step_inc;
          if (edge_fault) begin
            fault_d = 1'b1;
            done_d  = 1'b1;
            fsm_d   = FINISH;
          end else begin
            if (ent_mv == MV_LEFT) begin
              head_d = head_q - 1'b1;
            end else if (ent_mv == MV_RIGHT) begin
              head_d = head_q + 1'b1;
            end
`ifdef TM_STEP_LIMIT_EN
            // Halt and fault are already handled above, so they win over
            // a timeout on the same step.
            if (step_inc == 16'(MAX_STEPS)) begin
              timeout_d = 1'b1;
              done_d    = 1'b1;
              fsm_d     = FINISH;
            end else begin
              fsm_d     = FETCH;
            end
`else
            fsm_d = FETCH;
`endif
          end
        end
      end
      FINISH:  fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // State registers. FETCH latches the symbol under the head, and LOOKUP
  // latches the table entry selected by that symbol and the current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      head_q      <= '0;
      cur_state_q <= '0;
      step_q      <= '0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      sym_q       <= '0;
      entry_q     <= '0;
    end else begin
      fsm_q       <= fsm_d;
      head_q      <= head_d;
      cur_state_q <= cur_state_d;
      step_q      <= step_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
      if (fsm_q == FETCH) begin
        sym_q <= tape_mem[head_q];
      end
      if (fsm_q == LOOKUP) begin
        entry_q <= tbl_mem[{cur_state_q, sym_q}];
      end
    end
  end

`ifdef TM_STEP_LIMIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: doc/turing_engine.md
TURING_ENGINE -- requirements
Module: turing_engine

Interface
REQ-001 Parameter SW, default 2: tape symbol width in bits (2^SW symbols).
REQ-002 Parameter SB, default 3: state-number width (2^SB states).
REQ-003 Parameter TL, default 32: tape length in cells; HW = $clog2(TL).
REQ-004 Parameter MAX_STEPS, default 1000: step budget, used only under TM_STEP_LIMIT_EN.
REQ-005 clock  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 tbl_we  in  1  transition-table write strobe.
REQ-008 tbl_addr  in  SB+SW  table index = {state, symbol}.
REQ-009 tbl_data  in  SW+2+SB  entry = {write_sym, move[1:0], next_state}; move 00 left, 01 right, 10 stay, 11 halt.
REQ-010 tape_we  in  1  tape cell write strobe.
REQ-011 tape_addr  in  HW  tape cell index (write and readback).
REQ-012 tape_wdata  in  SW  symbol to write.
REQ-013 tape_rdata  out  SW  combinational readback of cell tape_addr.
REQ-014 start  in  1  begin a run (one-cycle pulse).
REQ-015 start_head  in  HW  initial head position.
REQ-016 start_state  in  SB  initial machine state.
REQ-017 busy  out  1  run in progress.
REQ-018 done  out  1  run finished; held until next start.
REQ-019 halted / fault / timeout  out  1 each  termination cause.
REQ-020 head  out  HW; cur_state  out  SB; step_count  out  16  live machine status.

Function
REQ-021 FSM states IDLE, FETCH, LOOKUP, EXEC, FINISH; each machine step SHALL take exactly 3 cycles (FETCH->LOOKUP->EXEC).
REQ-022 IDLE: tbl_we/tape_we SHALL write on the same edge; start SHALL load head=start_head, cur_state=start_state, clear step_count/done/halted/fault/timeout, go to FETCH.
REQ-023 tbl_we/tape_we SHALL be ignored whenever busy=1; start SHALL be ignored when busy=1.
REQ-024 FETCH SHALL latch tape[head]; LOOKUP SHALL latch table[{cur_state, latched symbol}].
REQ-025 EXEC, move != 11: write write_sym to tape[head], cur_state<=next_state, step_count+1, then move head; return to FETCH.
REQ-026 EXEC, move == 11: no tape write, no head/state change, step_count unchanged; halted=1; go to FINISH.
REQ-027 Left at head==0 or right at head==TL-1: tape write and state update SHALL still commit, head SHALL stay, fault=1, go to FINISH.
REQ-028 Stay (10) SHALL leave head unchanged and continue normally.
REQ-029 FINISH: done=1, busy=0, SHALL return to IDLE next cycle with done and cause flags held until next start.
REQ-030 step_count SHALL saturate at 16'hFFFF.
REQ-031 busy SHALL be 1 exactly in FETCH, LOOKUP, EXEC.

Reset
REQ-032 Reset SHALL force IDLE, head=0, cur_state=0, step_count=0, busy/done/halted/fault/timeout=0, at any time including mid-run.
REQ-033 Tape and table contents SHALL NOT be cleared by reset.

Configuration
REQ-034 Macro TM_STEP_LIMIT_EN defined: when EXEC commits a step making step_count==MAX_STEPS without halt/fault, timeout=1 and go to FINISH; halt/fault on the same step take priority.
REQ-035 TM_STEP_LIMIT_EN undefined: timeout SHALL be constant 0 and runs are unbounded.

Verification
REQ-036 SW=2,SB=3,TL=32; tape all 0; table[{0,0}]={1,01,0}, table[{0,1}]={1,11,0}; start head=0 -> done after 32 steps with fault=1, head=31, tape 0..31 all 1, step_count=32.
REQ-037 Binary increment program, tape cells 4..0 = 0,1,0,1,1 (LSB at 0), start head=0 -> halted=1, cells read back 0,1,1,0,0, step_count=3.
REQ-038 Entry move=00 at head=0 -> fault=1, head=0, tape[0]=write_sym, done=1 on cycle 4 after start.
REQ-039 Assert reset during LOOKUP of step 5 -> all outputs 0 next cycle, tape retains steps 1-4 writes; subsequent start runs correctly.
REQ-040 TM_STEP_LIMIT_EN, MAX_STEPS=10, stay-loop program -> timeout=1, step_count=10, busy fell 30 cycles after start; tape_we during run has no effect.
